// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch stage: issues a req/ack memory transaction for the PC and latches IR and PC+4.
// Optional REQ timeout fault is enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc_plus4,
  output logic        fetch_done,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic [1:0]  code_q, code_d;
  logic        timeout_s;

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter is held at zero outside REQ, so it is already clear on REQ entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_REQ) begin
      cnt_d = 8'd0;
    end else if (!mem_ack) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = (state_q == S_REQ) && !mem_ack &&
                     (cnt_q == 8'(TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush takes priority over ack; an ack that arrives with the limit still wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          if (pc[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_ack) begin
          state_d = S_DONE;
        end else if (timeout_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    busy       = 1'b1;
    fetch_done = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_IDLE:  busy       = 1'b0;
      S_REQ:   mem_req    = 1'b1;
      S_DONE:  fetch_done = 1'b1;
      S_ERR:   fault      = 1'b1;
      default: busy       = 1'b0;
    endcase
  end

  // IR and PC+4 move only on an accepted, unflushed ack.
  always_comb begin
    addr_d = addr_q;
    ir_d   = ir_q;
    pc4_d  = pc4_q;
    code_d = code_q;
    if (state_q == S_IDLE && fetch_start) begin
      if (pc[1:0] != 2'b00) begin
        code_d = 2'b01;
      end else begin
        addr_d = pc;
      end
    end else if (state_q == S_REQ && !flush) begin
      if (mem_ack) begin
        ir_d  = mem_rdata;
        pc4_d = addr_q + 32'd4;
      end else if (timeout_s) begin
        code_d = 2'b10;
      end else begin
        code_d = code_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= 32'h0000_0000;
      ir_q   <= 32'h0000_0000;
      pc4_q  <= 32'h0000_3004;
      code_q <= 2'b00;
    end else begin
      addr_q <= addr_d;
      ir_q   <= ir_d;
      pc4_q  <= pc4_d;
      code_q <= code_d;
    end
  end

  assign mem_addr   = addr_q;
  assign ir         = ir_q;
  assign pc_plus4   = pc4_q;
  assign fault_code = code_q;

endmodule
